display_driver: RTL

Downstream consumer of the calculator control unit and datapath. It captures the result on each `done` pulse and time-multiplexes a 4-digit common-anode 7-segment display: the current FSM state code is on the left digit and the held result in hex on the right two digits. It also stretches the one-cycle `done` pulse into a visible LED indication.

---
 rtl/display_driver.sv | 124 ++++++++++++
 1 files changed

// File: rtl/display_driver.sv
// Result capture, done-pulse stretcher and 4-digit multiplexed 7-segment scan
// for the calculator: FSM state code on the left digit, result hex on the right two.
module display_driver #(
   parameter int DW      = 8,
   parameter int DIV     = 16,
   parameter int STRETCH = 1000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    cs,
   input  logic [DW-1:0] out,
   input  logic          done,
   output logic [3:0]    an,
   output logic [6:0]    seg,
   output logic          dp,
   output logic          done_led,
   output logic [7:0]    result
);

   localparam int SCW = $clog2(STRETCH + 1);
   localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [SCW-1:0] SC_LOAD = SCW'(STRETCH);
   localparam logic [PCW-1:0] PC_LAST = PCW'(DIV - 1);
   localparam logic [6:0]     BLANK   = 7'b1111111;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction

   logic           done_q;
   logic [7:0]     result_q, result_d;
   logic [SCW-1:0] sc_q, sc_d;
   logic           done_led_q, done_led_d;
   logic [PCW-1:0] pc_q, pc_d;
   logic [1:0]     di_q, di_d;
   logic [3:0]     an_q, an_d;
   logic [6:0]     seg_q, seg_d;
   logic           dp_q, dp_d;
   logic           rise, pc_wrap, blank;
   logic [3:0]     nib;

   always_comb begin
      rise     = done & ~done_q;
      result_d = rise ? 8'(out) : result_q;

      // Held at STRETCH while done is high, so the tail is timed from the falling edge.
      if (done)
         sc_d = SC_LOAD;
      else if (sc_q != '0)
         sc_d = sc_q - SCW'(1);
      else
         sc_d = sc_q;
      done_led_d = done | (sc_q != '0);

      pc_wrap = (pc_q == PC_LAST);
      pc_d    = pc_wrap ? '0 : pc_q + PCW'(1);
      di_d    = pc_wrap ? di_q + 2'd1 : di_q;
   end

   always_comb begin
      nib   = 4'h0;
      blank = 1'b0;
      case (di_q)
         2'd0: nib = result_q[3:0];
         2'd1: begin
            nib   = result_q[7:4];
            blank = (DW <= 4);
         end
         2'd2: blank = 1'b1;
         default: nib = cs;
      endcase
      an_d  = ~(4'b0001 << di_q);
      seg_d = blank ? BLANK : hex7(nib);
      dp_d  = ~((di_q == 2'd3) & done_led_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q     <= 1'b0;
         result_q   <= '0;
         sc_q       <= '0;
         done_led_q <= 1'b0;
         pc_q       <= '0;
         di_q       <= '0;
         an_q       <= 4'b1111;
         seg_q      <= BLANK;
         dp_q       <= 1'b1;
      end else begin
         done_q     <= done;
         result_q   <= result_d;
         sc_q       <= sc_d;
         done_led_q <= done_led_d;
         pc_q       <= pc_d;
         di_q       <= di_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign an       = an_q;
   assign seg      = seg_q;
   assign dp       = dp_q;
   assign done_led = done_led_q;
   assign result   = result_q;

endmodule
